uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter control/datapath pair among NUM_REQ byte-producing requesters.
- Arbitrates round-robin, latches the winning byte, pulses the transmitter start, and waits for the frame to complete.
- Supports optional per-requester burst lock so multi-byte packets go out uninterleaved; burst length is capped to bound starvation.
- Sits between requester FIFOs/producers and the transmitter's start/ready interface.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 16: maximum consecutive bytes one locked requester may send before forced rotation, 1..255.
- IDW, $clog2(NUM_REQ): grant index width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  bit i: requester i has a byte on its slice of req_data.
- req_data  in  8*NUM_REQ  packed bytes; requester i on bits [8i+7:8i].
- req_lock  in  NUM_REQ  bit i: requester i requests to keep the grant after its current byte.
- req_ack  out  NUM_REQ  one-cycle pulse; byte of requester i was accepted; requester may change data next cycle.
- tx_ready  in  1  transmitter idle (high in its idle state, low while shifting a frame).
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to transmit; held stable from ISSUE until return to IDLE.
- grant_id  out  IDW  index of current/last owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; tx_start=0, tx_data=0, req_ack=0, busy=0, grant_id=NUM_REQ-1 (so requester 0 wins first), burst_cnt=0, owner_locked=0.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE: if tx_ready=1 and an eligible requester exists -> latch winner's byte into tx_data, grant_id<=winner, req_ack[winner]=1 (combinational pulse in this cycle), -> ISSUE. Otherwise stay.
- Eligibility: if owner_locked=1, only grant_id is eligible (others blocked even if owner not valid). Otherwise round-robin: search from grant_id+1 upward, modulo NUM_REQ; first req_valid wins.
- ISSUE: tx_start=1 for exactly one cycle -> WAIT_LOW.
- WAIT_LOW: wait until tx_ready=0 (transmitter left idle) -> WAIT_HIGH. If tx_ready still 1 after 2 cycles in WAIT_LOW, re-enter ISSUE (re-pulse start); no extra req_ack.
- WAIT_HIGH: wait until tx_ready=1 -> IDLE. On this transition update lock:
  - if req_lock[grant_id]=1 and burst_cnt < MAX_BURST-1: owner_locked<=1, burst_cnt<=burst_cnt+1;
  - else: owner_locked<=0, burst_cnt<=0.
- Lock released mid-wait: if owner_locked=1 in IDLE and req_lock[grant_id] drops, owner_locked clears the same cycle and round-robin resumes next cycle.
- Minimum throughput: a byte every frame time + 3 clk (IDLE, ISSUE, WAIT_LOW detection).
- req_valid dropping after ack has no effect; req_valid without ack must be held (no-drop requirement on requesters).
- Simultaneous: all valid, none locked -> strict rotation 0,1,2,3,0... Lock and valid of the same requester coincide with rotation -> lock only takes effect after that requester is granted.
- grant_id wraps NUM_REQ-1 -> 0; NUM_REQ not a power of 2: indices >= NUM_REQ never produced.
- Reset mid-frame: arbiter returns to IDLE; no ack is replayed; transmitter is reset by the same rst.

Test Plan:
- Single request: req_valid=4'b0100, data2=8'hA5 -> req_ack=4'b0100 for 1 cycle, tx_start 1 cycle later with tx_data=8'hA5, grant_id=2, busy high until tx_ready returns.
- All four valid, no lock, data 8'h10..8'h13 -> transmit order 10,11,12,13,10; exactly one ack per byte.
- Requester 1 lock held with valid, others valid, MAX_BURST=3 -> bytes 1,1,1, then 2,3,0, then 1 again.
- Lock holder drops valid but keeps lock -> no grants to others (busy=0, tx_start=0); dropping lock -> next requester (grant_id+1) granted within 2 cycles.
- tx_ready held high after start (transmitter missed it) -> tx_start re-pulsed after 2 cycles in WAIT_LOW, no second ack.
- Assert rst low during WAIT_HIGH -> all outputs 0, grant_id=3 asynchronously; after release, valid on req 0 -> req 0 served first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers, with an optional per-requester burst lock capped at MAX_BURST.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 tx_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  localparam logic [IDW:0] NUM_REQ_W  = (IDW+1)'(NUM_REQ);
  localparam logic [7:0]   BURST_LAST = 8'(MAX_BURST - 1);

  state_t         state_q, state_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           busy_q, busy_d;
  logic [7:0]     burst_cnt_q, burst_cnt_d;
  logic           owner_locked_q, owner_locked_d;
  logic           wl_cnt_q, wl_cnt_d;

  logic [NUM_REQ-1:0] ack_vec;
  logic [7:0]         req_byte [NUM_REQ];
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW:0]       cand;
  logic               grant_ok;
  logic [IDW-1:0]     grant_sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // Round-robin search: first valid requester after the last owner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, grant_id_q} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // A locked owner is the only candidate; otherwise the round-robin winner.
  always_comb begin
    grant_ok  = owner_locked_q ? req_valid[grant_id_q] : win_found;
    grant_sel = owner_locked_q ? grant_id_q : win_idx;
  end

  // Next-state logic for the arbiter sequencer and its registered outputs.
  always_comb begin
    state_d        = state_q;
    tx_data_d      = tx_data_q;
    grant_id_d     = grant_id_q;
    burst_cnt_d    = burst_cnt_q;
    owner_locked_d = owner_locked_q;
    wl_cnt_d       = wl_cnt_q;
    ack_vec        = '0;
    case (state_q)
      S_IDLE: begin
        if (owner_locked_q && !req_lock[grant_id_q]) begin
          // Owner abandoned its burst while idle: unlock, rotate next cycle.
          owner_locked_d = 1'b0;
          burst_cnt_d    = '0;
        end else if (tx_ready && grant_ok) begin
          tx_data_d          = req_byte[grant_sel];
          grant_id_d         = grant_sel;
          ack_vec[grant_sel] = 1'b1;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wl_cnt_d = 1'b0;
        state_d  = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!tx_ready) begin
          state_d = S_WAIT_HIGH;
        end else if (wl_cnt_q) begin
          // Transmitter never left idle: pulse start again, same byte.
          state_d = S_ISSUE;
        end else begin
          wl_cnt_d = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (tx_ready) begin
          state_d = S_IDLE;
          if (req_lock[grant_id_q] && (burst_cnt_q < BURST_LAST)) begin
            owner_locked_d = 1'b1;
            burst_cnt_d    = burst_cnt_q + 8'd1;
          end else begin
            owner_locked_d = 1'b0;
            burst_cnt_d    = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_start_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers; grant_id resets to the last index so 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      grant_id_q     <= IDW'(NUM_REQ - 1);
      busy_q         <= 1'b0;
      burst_cnt_q    <= '0;
      owner_locked_q <= 1'b0;
      wl_cnt_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      grant_id_q     <= grant_id_d;
      busy_q         <= busy_d;
      burst_cnt_q    <= burst_cnt_d;
      owner_locked_q <= owner_locked_d;
      wl_cnt_q       <= wl_cnt_d;
    end
  end

  assign req_ack  = ack_vec;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ack;
  logic           tx_ready = 1'b1;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ack(req_ack), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id), .busy(busy)
  );

  // Simple transmitter: a seen start drops ready for frame_len cycles.
  logic start_seen = 1'b0;
  int   frame_left = 0;
  int   frame_len  = 4;
  bit   miss_mode  = 1'b0;
  always @(negedge clk) start_seen = tx_start;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      tx_ready   = 1'b1;
      frame_left = 0;
    end else if (frame_left > 0) begin
      frame_left = frame_left - 1;
      if (frame_left == 0) tx_ready = 1'b1;
    end else if (start_seen && tx_ready && !miss_mode) begin
      tx_ready   = 1'b0;
      frame_left = frame_len;
    end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Reference model state, per transaction.
  logic [1:0]     m_last;
  bit             m_locked;
  int             m_cnt;
  logic [7:0]     exp_data;
  bit             start_due;
  bit             prev_busy;
  logic [N-1:0]   prev_lock;
  logic [7:0]     sent [$];
  int             glog [$];
  int             dut_acks;
  int             mode;
  int             target;
  logic [N-1:0]   nx_valid = '0, nx_lock = '0;
  logic [8*N-1:0] nx_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict(output bit found, output logic [1:0] widx);
    logic [1:0] idx;
    found = 1'b0;
    widx  = '0;
    if (m_locked) begin
      found = req_valid[m_last];
      widx  = m_last;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = 2'((int'(m_last) + k) % N);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          widx  = idx;
        end
      end
    end
  endtask

  task automatic eval();
    bit         found;
    logic [1:0] widx;
    logic [N-1:0] e_ack;
    chk("grant_id", 32'(grant_id), 32'(m_last));
    if (prev_busy && !busy) begin
      if (prev_lock[m_last] && m_cnt < MAXB - 1) begin
        m_locked = 1'b1;
        m_cnt    = m_cnt + 1;
      end else begin
        m_locked = 1'b0;
        m_cnt    = 0;
      end
    end
    if (start_due) begin
      chk("start_after_ack", 32'(tx_start), 32'd1);
      chk("busy_after_ack", 32'(busy), 32'd1);
      sent.push_back(tx_data);
      start_due = 1'b0;
    end
    if (tx_start) chk("tx_data", 32'(tx_data), 32'(exp_data));
    dut_acks += $countones(req_ack);
    found = 1'b0;
    widx  = '0;
    if (!busy) begin
      if (m_locked && !req_lock[m_last]) begin
        m_locked = 1'b0;
        m_cnt    = 0;
      end else if (tx_ready) begin
        predict(found, widx);
      end
    end
    e_ack = found ? (N'(1) << widx) : '0;
    chk("req_ack", 32'(req_ack), 32'(e_ack));
    if (found) begin
      m_last    = widx;
      exp_data  = req_data[{widx, 3'b000} +: 8];
      start_due = 1'b1;
      glog.push_back(int'(widx));
      case (mode)
        1: nx_valid[widx] = 1'b0;
        2: if ($urandom_range(0, 1) == 0) nx_valid[widx] = 1'b0;
           else nx_data[{widx, 3'b000} +: 8] = 8'($urandom);
        default: ;
      endcase
      if (target > 0 && glog.size() >= target) nx_valid = '0;
    end
    prev_busy = busy;
    prev_lock = req_lock;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = nx_valid;
    req_lock  = nx_lock;
    req_data  = nx_data;
    @(negedge clk);
    if (rst) eval();
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    nx_valid  = '0;
    nx_lock   = '0;
    req_valid = '0;
    req_lock  = '0;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    m_last    = 2'(N - 1);
    m_locked  = 1'b0;
    m_cnt     = 0;
    start_due = 1'b0;
    prev_busy = 1'b0;
    prev_lock = '0;
    sent.delete();
    glog.delete();
    dut_acks  = 0;
    target    = 0;
    mode      = 0;
    miss_mode = 1'b0;
    frame_len = 4;
  endtask

  task automatic wait_idle();
    int c = 0;
    do begin
      tick();
      c++;
    end while ((busy || start_due) && c < 300);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic [7:0] e3 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  int         e4 [10] = '{0, 1, 1, 1, 2, 3, 0, 1, 1, 1};

  initial begin
    int c, got, starts, second_at, acks;
    logic [N-1:0] bitm;
    #2;

    // Single request from requester 2.
    do_reset();
    mode     = 1;
    nx_valid = 4'b0100;
    nx_data  = 32'h00A5_0000;
    tick();
    chk("t2_ack", 32'(req_ack), 32'h4);
    tick();
    chk("t2_start", 32'(tx_start), 32'd1);
    chk("t2_data", 32'(tx_data), 32'hA5);
    chk("t2_grant", 32'(grant_id), 32'd2);
    c = 0;
    while (busy && c < 40) begin
      tick();
      if (!tx_ready) chk("t2_busy_in_frame", 32'(busy), 32'd1);
      c++;
    end
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_ready_back", 32'(tx_ready), 32'd1);

    // All valid, no lock: strict rotation.
    do_reset();
    nx_valid = 4'b1111;
    nx_data  = 32'h1312_1110;
    target   = 5;
    c = 0;
    while (glog.size() < 5 && c < 500) begin tick(); c++; end
    wait_idle();
    chk("t3_count", 32'(sent.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t3_order", (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF, 32'(e3[i]));
    chk("t3_one_ack_per_byte", 32'(dut_acks), 32'd5);

    // Burst lock on requester 1, capped at MAXB bytes.
    do_reset();
    nx_valid = 4'b1111;
    nx_lock  = 4'b0010;
    nx_data  = 32'h2322_2120;
    target   = 10;
    c = 0;
    while (glog.size() < 10 && c < 1000) begin tick(); c++; end
    nx_lock = '0;
    wait_idle();
    chk("t4_count", 32'(glog.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk("t4_order", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF, 32'(e4[i]));

    // Lock holder drops valid: others blocked until lock released.
    do_reset();
    mode     = 1;
    nx_lock  = 4'b0010;
    nx_valid = 4'b0010;
    nx_data  = 32'h0000_3300;
    tick();
    chk("t5_first_ack", 32'(req_ack), 32'h2);
    nx_valid = nx_valid | 4'b1101;
    nx_data  = 32'h4422_3311;
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_blocked_ack", 32'(req_ack), 32'd0);
      chk("t5_blocked_start", 32'(tx_start), 32'd0);
      chk("t5_blocked_busy", 32'(busy), 32'd0);
    end
    nx_lock = '0;
    got = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (req_ack == 4'b0100) got = 1;
    end
    chk("t5_release_grant", 32'(got), 32'd1);
    nx_valid = '0;
    wait_idle();

    // Transmitter misses the start: re-pulse, no second ack.
    do_reset();
    miss_mode = 1'b1;
    mode      = 1;
    nx_valid  = 4'b0001;
    nx_data   = 32'h0000_005A;
    tick();
    chk("t6_ack", 32'(req_ack), 32'h1);
    starts = 0; second_at = 0; acks = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (tx_start) starts++;
      if (starts == 2 && second_at == 0) second_at = i;
      acks += $countones(req_ack);
    end
    miss_mode = 1'b0;
    chk("t6_starts", 32'(starts), 32'd2);
    chk("t6_repulse_cycle", 32'(second_at), 32'd4);
    chk("t6_no_extra_ack", 32'(acks), 32'd0);
    wait_idle();

    // Reset during WAIT_HIGH, then requester 0 served first.
    do_reset();
    frame_len = 6;
    mode      = 1;
    nx_valid  = 4'b0001;
    nx_data   = 32'h0000_0077;
    tick();
    c = 0;
    while (!(busy && !tx_ready) && c < 20) begin tick(); c++; end
    tick();
    chk("t7_in_frame", 32'({busy, tx_ready}), 32'h2);
    #2;
    do_reset();
    mode     = 1;
    nx_valid = 4'b0011;
    nx_data  = 32'h0000_BBAA;
    tick();
    chk("t7_first_after_rst", 32'(req_ack), 32'h1);
    nx_valid = '0;
    wait_idle();

    // Randomized traffic with random locks and frame lengths.
    do_reset();
    mode = 2;
    for (int t = 0; t < 2000; t++) begin
      frame_len = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        bitm = N'(1) << i;
        if ((nx_valid & bitm) == '0 && $urandom_range(0, 2) == 0) begin
          nx_valid = nx_valid | bitm;
          nx_data[8*i +: 8] = 8'($urandom);
        end
        if ($urandom_range(0, 15) == 0) nx_lock = nx_lock ^ bitm;
      end
      tick();
    end
    nx_valid = '0;
    nx_lock  = '0;
    wait_idle();
    chk("rand_progress", 32'(glog.size() > 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
